// File: rtl/dualmem_pkg.sv
// Shared types and helpers for the dualmem_widen_buf width-converting buffer.
// DUALMEM_WIDEN_OUTREG_EN selects the registered-output (latency 2) read path.
package dualmem_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

`ifdef DUALMEM_WIDEN_OUTREG_EN
  localparam int RD_LAT = 2;
`else
  localparam int RD_LAT = 1;
`endif

  // Bit offset of narrow lane k inside a wide word.
  function automatic int lane_bit(input int k, input int narrow_w);
    return k * narrow_w;
  endfunction

  // Byte-enable offset of narrow lane k inside the wide byte-enable vector.
  function automatic int lane_byte(input int k, input int narrow_w);
    return k * (narrow_w / 8);
  endfunction

endpackage

// File: rtl/dualmem_lane.sv
// One narrow lane: true dual-port, byte-enabled, read-first RAM with registered read data.
// Vendor RAM primitives are substituted here only.
module dualmem_lane #(
  parameter int W     = 16,
  parameter int DEPTH = 512,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           a_en,
  input  logic           a_rd,
  input  logic [W/8-1:0] a_we,
  input  logic [AW-1:0]  a_addr,
  input  logic [W-1:0]   a_din,
  output logic [W-1:0]   a_dout,
  input  logic           b_en,
  input  logic           b_rd,
  input  logic [W/8-1:0] b_we,
  input  logic [AW-1:0]  b_addr,
  input  logic [W-1:0]   b_din,
  output logic [W-1:0]   b_dout
);

  logic [W-1:0] mem [DEPTH];

  // Array update; port B assignments come last so B wins a same-byte conflict
  always_ff @(posedge clk) begin
    if (a_en) begin
      for (int i = 0; i < W/8; i++) begin
        if (a_we[i]) mem[a_addr][i*8 +: 8] <= a_din[i*8 +: 8];
      end
    end
    if (b_en) begin
      for (int i = 0; i < W/8; i++) begin
        if (b_we[i]) mem[b_addr][i*8 +: 8] <= b_din[i*8 +: 8];
      end
    end
  end

  // Read-first output registers, updated only on reads so data holds otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_dout <= '0;
      b_dout <= '0;
    end else begin
      if (a_rd) a_dout <= mem[a_addr];
      if (b_rd) b_dout <= mem[b_addr];
    end
  end

endmodule

// File: rtl/dualmem_widen_buf.sv
// Dual-port narrow/wide width-converting buffer with clear engine and collision detect.
// Optional DUALMEM_WIDEN_OUTREG_EN adds an output register stage (read latency 2).
module dualmem_widen_buf
  import dualmem_pkg::*;
#(
  parameter int NARROW_W = 16,
  parameter int RATIO    = 4,
  parameter int DEPTH_A  = 2048
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clr_req,
  output logic                             busy,
  input  logic                             a_en,
  input  logic [NARROW_W/8-1:0]            a_we,
  input  logic [$clog2(DEPTH_A)-1:0]       a_addr,
  input  logic [NARROW_W-1:0]              a_din,
  output logic [NARROW_W-1:0]              a_dout,
  output logic                             a_vld,
  input  logic                             b_en,
  input  logic [NARROW_W*RATIO/8-1:0]      b_we,
  input  logic [$clog2(DEPTH_A/RATIO)-1:0] b_addr,
  input  logic [NARROW_W*RATIO-1:0]        b_din,
  output logic [NARROW_W*RATIO-1:0]        b_dout,
  output logic                             b_vld,
  output logic                             coll
);

  localparam int DEPTH_B = DEPTH_A / RATIO;
  localparam int L       = $clog2(RATIO);
  localparam int AW_A    = $clog2(DEPTH_A);
  localparam int AW_B    = $clog2(DEPTH_B);
  localparam int NB      = NARROW_W / 8;
  localparam int WW      = NARROW_W * RATIO;

  state_e            state_r, state_nxt;
  logic [AW_B-1:0]   ptr_r, ptr_nxt;

  logic [L-1:0]      a_lane_s;
  logic [AW_B-1:0]   a_word_s;
  logic              a_act_s, a_rd_s, b_act_s, b_rd_s;
  logic [L-1:0]      a_lane_r;
  logic              a_vld_r, b_vld_r, coll_r;
  logic [RATIO-1:0]  ovl_s;
  logic [NARROW_W-1:0] lane_a_dout [RATIO];
  logic [WW-1:0]     b_dout_s;
  logic [NARROW_W-1:0] a_dout_s;

  // Clear-engine state and pointer register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_CLEAR;
      ptr_r   <= '0;
    end else begin
      state_r <= state_nxt;
      ptr_r   <= ptr_nxt;
    end
  end

  // Clear-engine next state: one wide word zeroed per cycle, clr_req ignored while clearing
  always_comb begin
    state_nxt = state_r;
    ptr_nxt   = ptr_r;
    case (state_r)
      ST_IDLE: begin
        if (clr_req) begin
          state_nxt = ST_CLEAR;
          ptr_nxt   = '0;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        ptr_nxt = ptr_r + AW_B'(1);
        if (ptr_r == AW_B'(DEPTH_B - 1)) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_CLEAR;
        end
      end
      default: begin
        state_nxt = ST_CLEAR;
        ptr_nxt   = '0;
      end
    endcase
  end

  assign busy     = (state_r == ST_CLEAR);
  assign a_lane_s = a_addr[L-1:0];
  assign a_word_s = a_addr[AW_A-1:L];
  assign a_act_s  = a_en && !busy;
  assign a_rd_s   = a_act_s && (a_we == '0);
  assign b_act_s  = b_en && !busy;
  assign b_rd_s   = b_act_s && (b_we == '0);

  for (genvar k = 0; k < RATIO; k++) begin : g_lane
    logic lane_a_en_s;
    assign lane_a_en_s = a_act_s && (a_lane_s == L'(k));
    // Same-byte write/write overlap between port A and this lane of port B
    assign ovl_s[k] = lane_a_en_s && b_act_s && (a_word_s == b_addr) &&
                      (|(a_we & b_we[lane_byte(k, NARROW_W) +: NB]));

    dualmem_lane #(.W(NARROW_W), .DEPTH(DEPTH_B)) u_lane (
      .clk    (clk),
      .rst    (rst),
      .a_en   (lane_a_en_s),
      .a_rd   (lane_a_en_s && a_rd_s),
      .a_we   (a_we),
      .a_addr (a_word_s),
      .a_din  (a_din),
      .a_dout (lane_a_dout[k]),
      .b_en   (busy || b_act_s),
      .b_rd   (b_rd_s),
      .b_we   (busy ? {NB{1'b1}} : b_we[lane_byte(k, NARROW_W) +: NB]),
      .b_addr (busy ? ptr_r : b_addr),
      .b_din  (busy ? {NARROW_W{1'b0}} : b_din[lane_bit(k, NARROW_W) +: NARROW_W]),
      .b_dout (b_dout_s[lane_bit(k, NARROW_W) +: NARROW_W])
    );
  end

  // Read strobes, collision flag and the lane that the last A read came from
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_lane_r <= '0;
      a_vld_r  <= 1'b0;
      b_vld_r  <= 1'b0;
      coll_r   <= 1'b0;
    end else begin
      if (a_rd_s) a_lane_r <= a_lane_s;
      a_vld_r <= a_rd_s;
      b_vld_r <= b_rd_s;
      coll_r  <= |ovl_s;
    end
  end

  assign a_dout_s = lane_a_dout[a_lane_r];

`ifdef DUALMEM_WIDEN_OUTREG_EN
  // Extra output stage: every output delayed one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_dout <= '0;
      b_dout <= '0;
      a_vld  <= 1'b0;
      b_vld  <= 1'b0;
      coll   <= 1'b0;
    end else begin
      a_dout <= a_dout_s;
      b_dout <= b_dout_s;
      a_vld  <= a_vld_r;
      b_vld  <= b_vld_r;
      coll   <= coll_r;
    end
  end
`else
  assign a_dout = a_dout_s;
  assign b_dout = b_dout_s;
  assign a_vld  = a_vld_r;
  assign b_vld  = b_vld_r;
  assign coll   = coll_r;
`endif

endmodule
